fetch_unit: RTL and testbench

//   Program-counter and fetch-control stage sitting directly upstream of InstMem. Generates the

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program counter and fetch control feeding InstMem, with a one-entry skid
// register for stalls, branch/jump redirect with wrong-path squash, and an
// end-of-memory halt.
// Ports: clk, rst_n (sync, active low); i_stall; i_branch_taken,
//   i_branch_offset, i_jump_en, i_jump_target (redirect for inst at o_pc_id);
//   i_mem_instruction (registered InstMem data); o_address (pc to InstMem);
//   o_inst_id, o_pc_id, o_inst_valid (to decode); o_halted; o_addr_err.
module fetch_unit #(
    parameter int MEM_SIZE   = 64,
    parameter int RESET_PC   = 0,
    parameter int DELAY_SLOT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_offset,
    input  logic        i_jump_en,
    input  logic [25:0] i_jump_target,
    input  logic [31:0] i_mem_instruction,
    output logic [31:0] o_address,
    output logic [31:0] o_inst_id,
    output logic [31:0] o_pc_id,
    output logic        o_inst_valid,
    output logic        o_halted,
    output logic        o_addr_err
);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT} state_t;

    localparam logic [31:0] LP_LAST  = 32'(MEM_SIZE - 1);
    localparam logic [31:0] LP_SIZE  = 32'(MEM_SIZE);
    localparam logic [31:0] LP_RESET = 32'(RESET_PC);

    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic [31:0] r_pc_id, w_pc_id;
    logic        r_valid, w_valid;
    logic        r_halted, w_halted;
    logic        r_addr_err, w_addr_err;
    logic [31:0] r_skid, w_skid;
    logic        r_use_skid, w_use_skid;
    // Set while the delay-slot word is on o_inst_id; its redirect is ignored.
    logic        r_slot, w_slot;

    logic        w_fire;
    logic        w_hold;
    logic        w_redir;
    logic        w_bad;
    logic [31:0] w_pc1;
    logic [31:0] w_target;

    assign w_fire  = r_valid && !i_stall;
    assign w_hold  = r_valid && i_stall;
    assign w_redir = w_fire && !r_slot && (i_jump_en || i_branch_taken);
    assign w_pc1   = r_pc_id + 32'd1;
    assign w_target = i_jump_en ? {w_pc1[31:26], i_jump_target}
                                : w_pc1 + {{16{i_branch_offset[15]}},
                                           i_branch_offset};
    assign w_bad   = w_target >= LP_SIZE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_pc       <= LP_RESET;
            r_pc_id    <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_addr_err <= 1'b0;
            r_skid     <= '0;
            r_use_skid <= 1'b0;
            r_slot     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_pc       <= w_pc;
            r_pc_id    <= w_pc_id;
            r_valid    <= w_valid;
            r_halted   <= w_halted;
            r_addr_err <= w_addr_err;
            r_skid     <= w_skid;
            r_use_skid <= w_use_skid;
            r_slot     <= w_slot;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_pc       = r_pc;
        w_pc_id    = r_pc_id;
        w_valid    = r_valid;
        w_halted   = r_halted;
        w_addr_err = r_addr_err;
        w_skid     = r_skid;
        w_use_skid = r_use_skid;
        w_slot     = r_slot;
        if (w_hold) begin
            // InstMem moves on to word pc while held, so park the
            // current word; in HALT the memory output is already the
            // last word and needs no parking.
            if (r_state == S_RUN) begin
                w_skid     = i_mem_instruction;
                w_use_skid = 1'b1;
                w_state    = S_STALL;
            end
        end else if (w_redir) begin
            w_use_skid = 1'b0;
            w_pc_id    = r_pc;
            if (w_bad) begin
                w_state    = S_HALT;
                w_halted   = 1'b1;
                w_addr_err = 1'b1;
                w_valid    = 1'b0;
                w_slot     = 1'b0;
            end else begin
                w_pc     = w_target;
                w_state  = S_RUN;
                w_halted = 1'b0;
                // Delay slot word exists only if we were still fetching.
                w_valid  = (DELAY_SLOT != 0) && (r_state != S_HALT);
                w_slot   = (DELAY_SLOT != 0) && (r_state != S_HALT);
            end
        end else begin
            w_use_skid = 1'b0;
            if (w_fire) begin
                w_slot = 1'b0;
            end
            if (r_state == S_HALT) begin
                w_valid = 1'b0;
            end else begin
                w_pc_id = r_pc;
                w_valid = 1'b1;
                w_state = S_RUN;
                if (r_pc == LP_LAST) begin
                    w_state  = S_HALT;
                    w_halted = 1'b1;
                end else begin
                    w_pc = r_pc + 32'd1;
                end
            end
        end
    end

    assign o_address    = r_pc;
    assign o_inst_id    = r_use_skid ? r_skid : i_mem_instruction;
    assign o_pc_id      = r_pc_id;
    assign o_inst_valid = r_valid;
    assign o_halted     = r_halted;
    assign o_addr_err   = r_addr_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: three instances (default, delay slot,
// 8-word memory) share stimulus; each has its own InstMem model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] jt;

    logic [31:0] addr0, inst0, pcid0, mem0;
    logic        val0, hlt0, err0;
    logic [31:0] addr1, inst1, pcid1, mem1;
    logic        val1, hlt1, err1;
    logic [31:0] addr2, inst2, pcid2, mem2;
    logic        val2, hlt2, err2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // InstMem models: mem[i] = 0x100 + i, one-cycle registered read.
    always @(posedge clk) begin
        mem0 <= 32'h100 + addr0;
        mem1 <= 32'h100 + addr1;
        mem2 <= 32'h100 + addr2;
    end

    fetch_unit u0 (
        .clk(clk), .rst_n(rst_n), .i_stall(stall),
        .i_branch_taken(br), .i_branch_offset(off),
        .i_jump_en(jmp), .i_jump_target(jt),
        .i_mem_instruction(mem0), .o_address(addr0),
        .o_inst_id(inst0), .o_pc_id(pcid0), .o_inst_valid(val0),
        .o_halted(hlt0), .o_addr_err(err0)
    );

    fetch_unit #(.DELAY_SLOT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .i_stall(stall),
        .i_branch_taken(br), .i_branch_offset(off),
        .i_jump_en(jmp), .i_jump_target(jt),
        .i_mem_instruction(mem1), .o_address(addr1),
        .o_inst_id(inst1), .o_pc_id(pcid1), .o_inst_valid(val1),
        .o_halted(hlt1), .o_addr_err(err1)
    );

    fetch_unit #(.MEM_SIZE(8)) u2 (
        .clk(clk), .rst_n(rst_n), .i_stall(stall),
        .i_branch_taken(br), .i_branch_offset(off),
        .i_jump_en(jmp), .i_jump_target(jt),
        .i_mem_instruction(mem2), .o_address(addr2),
        .o_inst_id(inst2), .o_pc_id(pcid2), .o_inst_valid(val2),
        .o_halted(hlt2), .o_addr_err(err2)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Outputs are sampled on the falling edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; br = 1'b0;
        off = '0; jmp = 1'b0; jt = '0;
        @(negedge clk);

        // Reset state and sequential fetch
        do_reset();
        check("rst_addr", addr0, 32'd0);
        check("rst_valid", 32'(val0), 32'd0);
        check("rst_pcid", pcid0, 32'd0);
        check("rst_halted", 32'(hlt0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("seq_pcid", pcid0, 32'(k));
            check("seq_inst", inst0, 32'h100 + 32'(k));
            check("seq_valid", 32'(val0), 32'd1);
            check("seq_addr", addr0, 32'(k + 1));
        end

        // Stall three cycles at pc_id=4, release without bubble
        step();
        check("pre_stall_pcid", pcid0, 32'd4);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_pcid", pcid0, 32'd4);
            check("stall_inst", inst0, 32'h104);
            check("stall_valid", 32'(val0), 32'd1);
            check("stall_addr", addr0, 32'd5);
        end
        stall = 1'b0;
        step();
        check("rel_pcid", pcid0, 32'd5);
        check("rel_inst", inst0, 32'h105);
        check("rel_valid", 32'(val0), 32'd1);
        step();
        check("rel2_inst", inst0, 32'h106);

        // Branch at pc_id=3, offset +4 -> target 8
        do_reset();
        for (int k = 0; k < 4; k++) step();
        check("br_at", pcid0, 32'd3);
        br = 1'b1; off = 16'd4;
        step();
        br = 1'b0; off = '0;
        check("br_addr", addr0, 32'd8);
        check("br_squash", 32'(val0), 32'd0);
        check("ds_pcid", pcid1, 32'd4);
        check("ds_inst", inst1, 32'h104);
        check("ds_valid", 32'(val1), 32'd1);
        check("ds_addr", addr1, 32'd8);
        step();
        check("br_pcid", pcid0, 32'd8);
        check("br_inst", inst0, 32'h108);
        check("br_valid", 32'(val0), 32'd1);
        check("ds_tgt_pcid", pcid1, 32'd8);
        check("ds_tgt_inst", inst1, 32'h108);

        // Jump and branch together at pc_id=2: jump to 10 wins
        do_reset();
        for (int k = 0; k < 3; k++) step();
        check("jb_at", pcid0, 32'd2);
        br = 1'b1; off = 16'hFFFE; jmp = 1'b1; jt = 26'd10;
        step();
        br = 1'b0; off = '0; jmp = 1'b0; jt = '0;
        check("jb_addr", addr0, 32'd10);
        check("jb_squash", 32'(val0), 32'd0);
        step();
        check("jb_pcid", pcid0, 32'd10);
        check("jb_inst", inst0, 32'h10A);

        // 8-word memory: run off the end
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step();
            check("end_pcid", pcid2, 32'(k));
            check("end_valid", 32'(val2), 32'd1);
            check("end_halted", 32'(hlt2), 32'(k == 7));
        end
        check("end_last_inst", inst2, 32'h107);
        step();
        check("end_after_valid", 32'(val2), 32'd0);
        check("end_after_halted", 32'(hlt2), 32'd1);
        check("end_after_err", 32'(err2), 32'd0);
        check("end_after_addr", addr2, 32'd7);
        step();
        check("end_stays_valid", 32'(val2), 32'd0);

        // 8-word memory: jump to 20 is out of range
        do_reset();
        for (int k = 0; k < 4; k++) step();
        check("bad_at", pcid2, 32'd3);
        jmp = 1'b1; jt = 26'd20;
        step();
        jmp = 1'b0; jt = '0;
        check("bad_halted", 32'(hlt2), 32'd1);
        check("bad_err", 32'(err2), 32'd1);
        check("bad_valid", 32'(val2), 32'd0);
        step();
        check("bad_err_sticky", 32'(err2), 32'd1);

        // Stall while nothing valid is ignored; then reset mid-stall
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; stall = 1'b1;
        step();
        check("ign_pcid", pcid0, 32'd0);
        check("ign_valid", 32'(val0), 32'd1);
        check("ign_addr", addr0, 32'd1);
        step();
        check("hold_pcid", pcid0, 32'd0);
        check("hold_inst", inst0, 32'h100);
        check("hold_addr", addr0, 32'd1);
        rst_n = 1'b0;
        step();
        check("mrst_valid", 32'(val0), 32'd0);
        check("mrst_addr", addr0, 32'd0);
        check("mrst_err", 32'(err2), 32'd0);
        rst_n = 1'b1; stall = 1'b0;
        step();
        check("mrst_pcid", pcid0, 32'd0);
        check("mrst_inst", inst0, 32'h100);
        step();
        check("mrst_inst2", inst0, 32'h101);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
